clock_time_controller: RTL and testbench
========================================

// Module: clock_time_controller
// PURPOSE
//   Timekeeping and set-mode sequencer for the clock display path. Divides the system clock
//   to a 1 Hz tick and maintains the hour (0-23), min (0-59) and sec (0-59) counters.
//   Runs the RUN / SET_HOUR / SET_MIN state machine from push-button pulses.
//   Drives the time-to-digit converter (hour, min, sec, min_or_sec) and blanking flags for set-mode blink.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock cycles per second tick (>=2)
//   BLINK_DIV  12_500_000  cycles per blink half-period in set modes (>=1)
// PORTS
//   clk           in   1  system clock, all logic on rising edge
//   reset         in   1  asynchronous, active-high; clears all state
//   btn_mode      in   1  1-cycle pulse, clk-synchronous (debounced upstream): advance mode
//   btn_inc       in   1  1-cycle pulse: increment field being set
//   btn_view      in   1  1-cycle pulse: toggle HH:MM / SS view (RUN only)
//   hour          out  5  current hour 0..23
//   min           out  6  current minute 0..59
//   sec           out  6  current second 0..59
//   min_or_sec    out  1  0 = show hour:min, 1 = show sec; feeds converter select
//   blank_hour    out  1  1 = hour digits blanked (blink off-phase)
//   blank_minsec  out  1  1 = min/sec digits blanked
//   mode          out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)
//   tick_1hz      out  1  1-cycle pulse in the cycle the seconds counter advances
// BEHAVIOUR
//   Reset: hour=min=sec=0, min_or_sec=0, blank_*=0, mode=RUN, tick_1hz=0, prescaler=0, blink phase=0.
//   All outputs registered; a button pulse in cycle N is visible on outputs at cycle N+1.
//   Prescaler (ceil(log2 CLK_HZ) bits): in RUN counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0 and
//   asserts tick_1hz for the next cycle, together with the sec update. First tick after reset: cycle CLK_HZ.
//   RUN tick: sec+1; sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0.
//   23:59:59 + tick -> 00:00:00.
//   FSM on btn_mode: RUN->SET_HOUR->SET_MIN->RUN.
//   - Entering SET_HOUR: sec<=0, prescaler<=0, min_or_sec<=0, blink counter<=0, blink phase<=0.
//   - In SET_HOUR/SET_MIN: prescaler and sec held at 0; tick_1hz never asserted.
//   - SET_MIN->RUN: prescaler restarts at 0; next tick exactly CLK_HZ cycles after the pulse.
//   btn_inc:
//   - SET_HOUR: hour = (hour+1) mod 24.
//   - SET_MIN: min = (min+1) mod 60, no carry into hour.
//   - Ignored in RUN.
//   btn_view: toggles min_or_sec in RUN only; ignored in set modes (min_or_sec forced 0).
//   Simultaneous pulses: btn_mode has priority; btn_inc/btn_view in the same cycle are dropped.
//   A RUN tick coinciding with btn_mode still applies its sec increment; the transition then clears sec.
//   Net result: sec=0.
//   Blink: in set modes the counter runs 0..BLINK_DIV-1; at BLINK_DIV-1 it wraps and phase toggles.
//   Counter and phase restart at 0 on every mode change. In RUN they are held at 0.
//   blank_hour = (mode==SET_HOUR)&phase; blank_minsec = (mode==SET_MIN)&phase.
//   btn_inc does not disturb blink timing.
//   Reset asserted mid-operation (any state, any counter value): immediate return to reset values.
//   On release, resumes in RUN at 00:00:00.
// TESTING (CLK_HZ=4, BLINK_DIV=2)
//   Reset release, idle 12 cycles -> tick_1hz pulses at cycles 4, 8, 12; sec=1, 2, 3.
//   Preload via set: hour=23, min=59 (23 inc, 59 inc), back to RUN, run 60 ticks.
//   -> reaches 23:59:59, next tick 00:00:00.
//   btn_mode at sec=37 -> mode=01, sec=0, min_or_sec=0, no ticks.
//   blank_hour toggles every 2 cycles starting 0.
//   SET_HOUR at hour=23 + btn_inc -> hour=0.
//   SET_MIN at min=59 + btn_inc -> min=0, hour unchanged.
//   btn_mode and btn_inc same cycle in SET_HOUR with hour=5 -> mode=10, hour stays 5.
//   RUN: btn_view -> min_or_sec=1; again -> 0.
//   Assert reset mid-SET_MIN with min=42 -> all outputs 0, mode=00 asynchronously.

Source files
------------

// File: rtl/clock_time_controller.sv
// Clock timekeeping core: 1 Hz prescaler, hh:mm:ss counters, RUN/SET_HOUR/SET_MIN
// sequencer driven by debounced button pulses, and blink blanking for the set modes.
module clock_time_controller #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_view,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       min_or_sec,
    output logic       blank_hour,
    output logic       blank_minsec,
    output logic [1:0] mode,
    output logic       tick_1hz
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    mode_t         state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          phase, phase_nxt;
    logic [4:0]    hour_nxt;
    logic [5:0]    min_nxt, sec_nxt;
    logic          mos_nxt, blank_hour_nxt, blank_minsec_nxt, tick_nxt;

    // Hour field increment, wrapping 23 -> 0.
    function automatic logic [4:0] inc_hour(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute/second field increment, wrapping 59 -> 0.
    function automatic logic [5:0] inc_sexa(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign mode = state;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
        hour_nxt      = hour;
        min_nxt       = min;
        sec_nxt       = sec;
        mos_nxt       = min_or_sec;
        tick_nxt      = 1'b0;

        case (state)
            RUN: begin
                blink_cnt_nxt = '0;
                phase_nxt     = 1'b0;
                // The tick still carries through the time even if btn_mode
                // arrives in the same cycle; the mode change then clears sec.
                if (presc == PRESC_MAX) begin
                    presc_nxt = '0;
                    tick_nxt  = 1'b1;
                    sec_nxt   = inc_sexa(sec);
                    if (sec == 6'd59) begin
                        min_nxt = inc_sexa(min);
                        if (min == 6'd59) begin
                            hour_nxt = inc_hour(hour);
                        end
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end

                if (btn_mode) begin
                    state_nxt = SET_HOUR;
                    sec_nxt   = 6'd0;
                    presc_nxt = '0;
                    mos_nxt   = 1'b0;
                    tick_nxt  = 1'b0;
                end else if (btn_view) begin
                    mos_nxt = ~min_or_sec;
                end
            end

            SET_HOUR, SET_MIN: begin
                presc_nxt = '0;
                sec_nxt   = 6'd0;
                mos_nxt   = 1'b0;

                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt_nxt = '0;
                    phase_nxt     = ~phase;
                end else begin
                    blink_cnt_nxt = blink_cnt + BW'(1);
                end

                // btn_mode wins; a coincident btn_inc is dropped.
                if (btn_mode) begin
                    state_nxt     = (state == SET_HOUR) ? SET_MIN : RUN;
                    blink_cnt_nxt = '0;
                    phase_nxt     = 1'b0;
                end else if (btn_inc) begin
                    if (state == SET_HOUR) begin
                        hour_nxt = inc_hour(hour);
                    end else begin
                        min_nxt = inc_sexa(min);
                    end
                end
            end

            default: begin
                state_nxt     = RUN;
                presc_nxt     = '0;
                blink_cnt_nxt = '0;
                phase_nxt     = 1'b0;
                mos_nxt       = 1'b0;
            end
        endcase

        blank_hour_nxt   = (state_nxt == SET_HOUR) && phase_nxt;
        blank_minsec_nxt = (state_nxt == SET_MIN) && phase_nxt;
    end

    // State and output registers; reset returns everything to 00:00:00 in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            presc        <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
            hour         <= 5'd0;
            min          <= 6'd0;
            sec          <= 6'd0;
            min_or_sec   <= 1'b0;
            blank_hour   <= 1'b0;
            blank_minsec <= 1'b0;
            tick_1hz     <= 1'b0;
        end else begin
            state        <= state_nxt;
            presc        <= presc_nxt;
            blink_cnt    <= blink_cnt_nxt;
            phase        <= phase_nxt;
            hour         <= hour_nxt;
            min          <= min_nxt;
            sec          <= sec_nxt;
            min_or_sec   <= mos_nxt;
            blank_hour   <= blank_hour_nxt;
            blank_minsec <= blank_minsec_nxt;
            tick_1hz     <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with CLK_HZ=4, BLINK_DIV=2.
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_view = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       min_or_sec;
    logic       blank_hour;
    logic       blank_minsec;
    logic [1:0] mode;
    logic       tick_1hz;

    int tests = 0;
    int failed = 0;

    clock_time_controller #(
        .CLK_HZ   (4),
        .BLINK_DIV(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_view    (btn_view),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .min_or_sec  (min_or_sec),
        .blank_hour  (blank_hour),
        .blank_minsec(blank_minsec),
        .mode        (mode),
        .tick_1hz    (tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One-cycle button pulse driven from a falling edge; returns on the
    // falling edge after the consuming rising edge.
    task automatic pulse(input logic m, input logic i, input logic v);
        btn_mode = m;
        btn_inc  = i;
        btn_view = v;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_view = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) begin
            pulse(1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hour"}, 32'(hour), 32'd0);
        chk({tag, "_min"}, 32'(min), 32'd0);
        chk({tag, "_sec"}, 32'(sec), 32'd0);
        chk({tag, "_mos"}, 32'(min_or_sec), 32'd0);
        chk({tag, "_bh"}, 32'(blank_hour), 32'd0);
        chk({tag, "_bm"}, 32'(blank_minsec), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_tick"}, 32'(tick_1hz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] blink_pat;
        int guard;
        blink_pat = 8'b0110_0110;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // Ticks at cycles 4, 8, 12 after release
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("tick_c%0d", i), 32'(tick_1hz), (i % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("sec_c%0d", i), 32'(sec), 32'(i / 4));
        end

        // View toggle in RUN
        pulse(1'b0, 1'b0, 1'b1);
        chk("view_on", 32'(min_or_sec), 32'd1);
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("view_off", 32'(min_or_sec), 32'd0);

        // Advance to sec=37, then enter SET_HOUR with view on
        guard = 0;
        while (sec != 6'd37 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_sec37", 32'(guard < 1000), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("sethr_mode", 32'(mode), 32'd1);
        chk("sethr_sec", 32'(sec), 32'd0);
        chk("sethr_mos", 32'(min_or_sec), 32'd0);
        chk("sethr_bh0", 32'(blank_hour), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("blink_k%0d", k), 32'(blank_hour), 32'(blink_pat[k-1]));
            chk($sformatf("set_tick_k%0d", k), 32'(tick_1hz), 32'd0);
            chk($sformatf("set_bm_k%0d", k), 32'(blank_minsec), 32'd0);
        end
        chk("set_sec_held", 32'(sec), 32'd0);

        // Hour set and wrap
        inc_n(23);
        chk("hour_23", 32'(hour), 32'd23);
        inc_n(1);
        chk("hour_wrap", 32'(hour), 32'd0);
        inc_n(5);
        chk("hour_5", 32'(hour), 32'd5);
        pulse(1'b1, 1'b1, 1'b0);
        chk("modeinc_mode", 32'(mode), 32'd2);
        chk("modeinc_hour", 32'(hour), 32'd5);

        // Minute set and wrap without hour carry
        inc_n(59);
        chk("min_59", 32'(min), 32'd59);
        inc_n(1);
        chk("min_wrap", 32'(min), 32'd0);
        chk("min_wrap_hour", 32'(hour), 32'd5);
        inc_n(59);

        // Preload 23:59 and return to RUN
        pulse(1'b1, 1'b0, 1'b0);
        chk("back_run", 32'(mode), 32'd0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        inc_n(18);
        chk("pre_hour", 32'(hour), 32'd23);
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        chk("pre_mode", 32'(mode), 32'd0);
        chk("pre_min", 32'(min), 32'd59);
        chk("pre_sec", 32'(sec), 32'd0);

        // 60 ticks: first one exactly 4 cycles after the pulse, then midnight rollover
        for (int i = 1; i <= 240; i++) begin
            @(negedge clk);
            if (i == 3) chk("run_tick_c3", 32'(tick_1hz), 32'd0);
            if (i == 4) begin
                chk("run_tick_c4", 32'(tick_1hz), 32'd1);
                chk("run_sec_c4", 32'(sec), 32'd1);
            end
            if (i == 236) begin
                chk("pre_mid_hour", 32'(hour), 32'd23);
                chk("pre_mid_min", 32'(min), 32'd59);
                chk("pre_mid_sec", 32'(sec), 32'd59);
            end
        end
        chk("mid_tick", 32'(tick_1hz), 32'd1);
        chk("mid_hour", 32'(hour), 32'd0);
        chk("mid_min", 32'(min), 32'd0);
        chk("mid_sec", 32'(sec), 32'd0);

        // Asynchronous reset in SET_MIN with min=42
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        inc_n(42);
        chk("setmin_mode", 32'(mode), 32'd2);
        chk("setmin_42", 32'(min), 32'd42);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("arst");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_tick3", 32'(tick_1hz), 32'd0);
        @(negedge clk);
        chk("post_rst_tick4", 32'(tick_1hz), 32'd1);
        chk("post_rst_sec", 32'(sec), 32'd1);
        chk("post_rst_mode", 32'(mode), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
